spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 148 ++++++++++++++
 tb/tb_spi_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master: sends one 40-bit frame {Addr, Wr_Data} and captures a 32-bit reply.
// Define SPI_MASTER_MISO_SYNC_EN to pass SPI_MISO through a two-flop synchronizer.
module spi_master #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Addr,
  input  logic [31:0] Wr_Data,
  output logic [31:0] Rd_Data,
  output logic        Busy,
  output logic        Done,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] shreg;
  logic [31:0] rx;
  logic        miso_bit;
  logic        sample_en;
  logic        last_hp;
  logic        last_gap;

  assign last_hp  = (cnt == 8'(HALF_PERIOD - 1));
  assign last_gap = (cnt == 8'(CS_GAP - 1));

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic miso_p0, miso_p1;

  // synchronizer stages p0 -> p1; late sampling leaves room for the two-cycle delay
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      miso_p0 <= 1'b0;
      miso_p1 <= 1'b0;
    end else begin
      miso_p0 <= SPI_MISO;
      miso_p1 <= miso_p0;
    end
  end

  assign miso_bit  = miso_p1;
  assign sample_en = (state == HIGH) && last_hp;
`else
  assign miso_bit  = SPI_MISO;
  assign sample_en = (state == HIGH) && (cnt == 8'd0);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      bit_cnt  <= 6'd0;
      shreg    <= 40'd0;
      rx       <= 32'd0;
      Rd_Data  <= 32'd0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      SPI_CLK  <= 1'b0;
      SPI_CS   <= 1'b1;
      SPI_MOSI <= 1'b0;
    end else begin
      Done <= 1'b0;
      // the first 8 captured bits line up with the address byte and are dropped
      if (sample_en && bit_cnt > 6'd8)
        rx <= {rx[30:0], miso_bit};
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= SETUP;
            Busy     <= 1'b1;
            SPI_CS   <= 1'b0;
            shreg    <= {Addr, Wr_Data};
            SPI_MOSI <= Addr[7];
            cnt      <= 8'd0;
            bit_cnt  <= 6'd0;
          end
        end
        SETUP: begin
          if (last_gap) begin
            state   <= HIGH;
            SPI_CLK <= 1'b1;
            cnt     <= 8'd0;
            bit_cnt <= bit_cnt + 6'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HIGH: begin
          if (last_hp) begin
            SPI_CLK <= 1'b0;
            cnt     <= 8'd0;
            if (bit_cnt == 6'd40) begin
              state <= HOLD;
            end else begin
              state    <= LOW;
              shreg    <= {shreg[38:0], 1'b0};
              SPI_MOSI <= shreg[38];
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LOW: begin
          if (last_hp) begin
            state   <= HIGH;
            SPI_CLK <= 1'b1;
            cnt     <= 8'd0;
            bit_cnt <= bit_cnt + 6'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (last_gap) begin
            state    <= GAP;
            SPI_CS   <= 1'b1;
            SPI_MOSI <= 1'b0;
            cnt      <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (last_gap) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Rd_Data <= rx;
            cnt     <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of frames plus ignored-start and mid-frame reset sequences.
module tb_spi_master;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Addr = 8'd0;
  logic [31:0] Wr_Data = 32'd0;
  logic [31:0] Rd_Data;
  logic        Busy, Done, SPI_CLK, SPI_CS, SPI_MOSI, SPI_MISO;

  spi_master #(.HALF_PERIOD(4), .CS_GAP(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Addr(Addr), .Wr_Data(Wr_Data),
    .Rd_Data(Rd_Data), .Busy(Busy), .Done(Done), .SPI_CLK(SPI_CLK),
    .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // slave model and bus monitor, all updated on the falling Clk edge
  logic [39:0] slave_word = 40'd0;
  logic [5:0]  fall_cnt   = 6'd0;
  logic [2:0]  dl         = 3'd0;
  logic        ideal;
  logic        prev_sclk  = 1'b0;
  logic [39:0] mosi_cap   = 40'd0;
  int edge_cnt = 0, busy_cnt = 0, done_cnt = 0, mosi_bad = 0;
  int cs_hi_run = 0, min_gap = 100000;

  always_comb begin
    ideal = 1'b0;
    if (!SPI_CS && fall_cnt < 6'd40) ideal = slave_word[6'd39 - fall_cnt];
  end
  assign SPI_MISO = dl[2];

  always @(negedge Clk) begin
    prev_sclk <= SPI_CLK;
    dl <= {dl[1:0], ideal};
    if (SPI_CLK && !prev_sclk) begin
      edge_cnt <= edge_cnt + 1;
      mosi_cap <= {mosi_cap[38:0], SPI_MOSI};
    end
    if (SPI_CS) fall_cnt <= 6'd0;
    else if (!SPI_CLK && prev_sclk) fall_cnt <= fall_cnt + 6'd1;
    if (Busy) busy_cnt <= busy_cnt + 1;
    if (Done) done_cnt <= done_cnt + 1;
    if (SPI_CS && SPI_MOSI) mosi_bad <= mosi_bad + 1;
    if (SPI_CS) cs_hi_run <= cs_hi_run + 1;
    else begin
      if (cs_hi_run != 0 && cs_hi_run < min_gap) min_gap <= cs_hi_run;
      cs_hi_run <= 0;
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [39:0] slave;
    logic [39:0] exp_mosi;
    logic [31:0] exp_rd;
    int          poke;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (Done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'd1);
  endtask

  task automatic do_frame(input vec_t v);
    int b0, e0, d0;
    b0 = busy_cnt; e0 = edge_cnt; d0 = done_cnt;
    slave_word = v.slave;
    Addr = v.addr; Wr_Data = v.wdata; Start = 1'b1;
    step();
    Start = 1'b0;
    check("cs_low_after_start", 64'(SPI_CS), 64'd0);
    check("busy_after_start", 64'(Busy), 64'd1);
    check("sclk_low_in_setup", 64'(SPI_CLK), 64'd0);
    check("mosi_first_bit", 64'(SPI_MOSI), 64'(v.addr[7]));
    if (v.poke >= 0) begin
      repeat (v.poke - 1) step();
      Addr = 8'h7E; Wr_Data = 32'h01234567; Start = 1'b1;
      step();
      Start = 1'b0;
    end
    wait_done();
    check("done_busy_low", 64'(Busy), 64'd0);
    check("rd_data", 64'(Rd_Data), 64'(v.exp_rd));
    check("busy_cycles", 64'(busy_cnt - b0), 64'd328);
    check("sclk_edges", 64'(edge_cnt - e0), 64'd40);
    check("mosi_word", 64'(mosi_cap), 64'(v.exp_mosi));
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int e0, d0;
    bit hit;
    vecs[0] = '{8'h85, 32'hDEADBEEF, 40'h0000000000, 40'h85DEADBEEF, 32'h00000000, -1};
    vecs[1] = '{8'h05, 32'h00000000, 40'hA512345678, 40'h0500000000, 32'h12345678, -1};
    vecs[2] = '{8'hFF, 32'hFFFFFFFF, 40'hFF80000001, 40'hFFFFFFFFFF, 32'h80000001, -1};
    vecs[3] = '{8'h85, 32'hDEADBEEF, 40'hC3A5A5A5A5, 40'h85DEADBEEF, 32'hA5A5A5A5, 10};
    vecs[4] = '{8'h00, 32'h00000001, 40'h5AFFFFFFFF, 40'h0000000001, 32'hFFFFFFFF, -1};

    repeat (3) step();
    check("rst_cs", 64'(SPI_CS), 64'd1);
    check("rst_sclk", 64'(SPI_CLK), 64'd0);
    check("rst_mosi", 64'(SPI_MOSI), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_rd_data", 64'(Rd_Data), 64'd0);
    Reset = 1'b0;
    repeat (3) step();

    // frames follow each other on the Done cycle
    for (int i = 0; i < 5; i++) do_frame(vecs[i]);

    // reset around the 20th rising SPI_CLK edge
    e0 = edge_cnt; d0 = done_cnt;
    slave_word = 40'hA512345678;
    Addr = 8'h05; Wr_Data = 32'h0; Start = 1'b1;
    step();
    Start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (edge_cnt - e0 == 20) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_edge_20", 64'(hit), 64'd1);
    Reset = 1'b1;
    #1;
    check("abort_cs", 64'(SPI_CS), 64'd1);
    check("abort_sclk", 64'(SPI_CLK), 64'd0);
    check("abort_mosi", 64'(SPI_MOSI), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_rd_data", 64'(Rd_Data), 64'd0);
    step();
    Reset = 1'b0;
    repeat (400) step();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_rd_kept_zero", 64'(Rd_Data), 64'd0);
    check("abort_idle_cs", 64'(SPI_CS), 64'd1);

    do_frame(vecs[1]);
    repeat (5) step();

    check("mosi_zero_when_cs_high", 64'(mosi_bad), 64'd0);
    check("cs_gap_min_ok", 64'(min_gap >= 4), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
